rvfi_serializer: RTL



---
 rtl/rvfi_serializer_if.sv | 84 ++++++++
 rtl/rvfi_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rvfi_serializer_if.sv
// rtl/rvfi_serializer_if.sv - multi-channel RVFI input bundle plus serialized single-channel output bus
//
// Ports (signals):
//   rvfi_*       NRET-wide packed RVFI retirement bundle from the core
//   out_*        one retirement per cycle toward a single-channel checker
//   overflow     sticky: a retirement was dropped
//   order_error  sticky: serialized order sequence broke (0 when check compiled out)
// Modports: master = core/checker side, slave = serializer.

interface rvfi_serializer_if #(
    parameter int NRET = 2,
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic [NRET-1:0]          rvfi_valid;
    logic [NRET*64-1:0]       rvfi_order;
    logic [NRET*ILEN-1:0]     rvfi_insn;
    logic [NRET-1:0]          rvfi_trap;
    logic [NRET-1:0]          rvfi_halt;
    logic [NRET-1:0]          rvfi_intr;
    logic [NRET*5-1:0]        rvfi_rs1_addr;
    logic [NRET*5-1:0]        rvfi_rs2_addr;
    logic [NRET*5-1:0]        rvfi_rd_addr;
    logic [NRET*XLEN-1:0]     rvfi_rs1_rdata;
    logic [NRET*XLEN-1:0]     rvfi_rs2_rdata;
    logic [NRET*XLEN-1:0]     rvfi_rd_wdata;
    logic [NRET*XLEN-1:0]     rvfi_pc_rdata;
    logic [NRET*XLEN-1:0]     rvfi_pc_wdata;
    logic [NRET*XLEN-1:0]     rvfi_mem_addr;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
    logic [NRET*XLEN-1:0]     rvfi_mem_rdata;
    logic [NRET*XLEN-1:0]     rvfi_mem_wdata;

    logic                     out_valid;
    logic [63:0]              out_order;
    logic [ILEN-1:0]          out_insn;
    logic                     out_trap;
    logic                     out_halt;
    logic                     out_intr;
    logic [4:0]               out_rs1_addr;
    logic [4:0]               out_rs2_addr;
    logic [4:0]               out_rd_addr;
    logic [XLEN-1:0]          out_rs1_rdata;
    logic [XLEN-1:0]          out_rs2_rdata;
    logic [XLEN-1:0]          out_rd_wdata;
    logic [XLEN-1:0]          out_pc_rdata;
    logic [XLEN-1:0]          out_pc_wdata;
    logic [XLEN-1:0]          out_mem_addr;
    logic [XLEN/8-1:0]        out_mem_rmask;
    logic [XLEN/8-1:0]        out_mem_wmask;
    logic [XLEN-1:0]          out_mem_rdata;
    logic [XLEN-1:0]          out_mem_wdata;
    logic                     overflow;
    logic                     order_error;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
               rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
        input  out_valid, out_order, out_insn, out_trap, out_halt, out_intr,
               out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_rs1_rdata, out_rs2_rdata, out_rd_wdata,
               out_pc_rdata, out_pc_wdata,
               out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata,
               overflow, order_error
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
               rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
        output out_valid, out_order, out_insn, out_trap, out_halt, out_intr,
               out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_rs1_rdata, out_rs2_rdata, out_rd_wdata,
               out_pc_rdata, out_pc_wdata,
               out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata,
               overflow, order_error
    );
endinterface

// File: rtl/rvfi_serializer.sv
// rtl/rvfi_serializer.sv - serializes NRET-wide RVFI retirements into one per cycle
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    rvfi_serializer_if.slave: rvfi_* in, out_*/overflow/order_error out
// Optional: define RVFI_SERIALIZER_ORDERCHK_EN to build the monotonic order checker.

module rvfi_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    rvfi_serializer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [63:0]       order;
        logic [ILEN-1:0]   insn;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          mem_d [DEPTH];
    rec_t          in_rec [NRET];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;
    logic          pop;
    logic          out_valid_q, out_valid_d;
    rec_t          out_rec_q, out_rec_d;
    logic          overflow_q, overflow_d;

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            in_rec[i].order     = bus.rvfi_order[i*64 +: 64];
            in_rec[i].insn      = bus.rvfi_insn[i*ILEN +: ILEN];
            in_rec[i].trap      = bus.rvfi_trap[i];
            in_rec[i].halt      = bus.rvfi_halt[i];
            in_rec[i].intr      = bus.rvfi_intr[i];
            in_rec[i].rs1_addr  = bus.rvfi_rs1_addr[i*5 +: 5];
            in_rec[i].rs2_addr  = bus.rvfi_rs2_addr[i*5 +: 5];
            in_rec[i].rd_addr   = bus.rvfi_rd_addr[i*5 +: 5];
            in_rec[i].rs1_rdata = bus.rvfi_rs1_rdata[i*XLEN +: XLEN];
            in_rec[i].rs2_rdata = bus.rvfi_rs2_rdata[i*XLEN +: XLEN];
            in_rec[i].rd_wdata  = bus.rvfi_rd_wdata[i*XLEN +: XLEN];
            in_rec[i].pc_rdata  = bus.rvfi_pc_rdata[i*XLEN +: XLEN];
            in_rec[i].pc_wdata  = bus.rvfi_pc_wdata[i*XLEN +: XLEN];
            in_rec[i].mem_addr  = bus.rvfi_mem_addr[i*XLEN +: XLEN];
            in_rec[i].mem_rmask = bus.rvfi_mem_rmask[i*(XLEN/8) +: XLEN/8];
            in_rec[i].mem_wmask = bus.rvfi_mem_wmask[i*(XLEN/8) +: XLEN/8];
            in_rec[i].mem_rdata = bus.rvfi_mem_rdata[i*XLEN +: XLEN];
            in_rec[i].mem_wdata = bus.rvfi_mem_wdata[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        int            n_acc;
        logic [PW-1:0] widx;
        mem_d      = mem_q;
        overflow_d = overflow_q;
        n_acc      = 0;
        widx       = '0;
        pop        = (count_q != '0);
        // The slot vacated by this cycle's pop is reusable by this cycle's push.
        free = CW'(DEPTH) - count_q + CW'(pop);
        // Valid channels are packed in ascending order with gaps squeezed out;
        // once free slots run out, the remaining higher channels are dropped.
        for (int i = 0; i < NRET; i++) begin
            if (bus.rvfi_valid[i]) begin
                if (n_acc < int'(free)) begin
                    widx        = PW'((int'(wptr_q) + n_acc) % DEPTH);
                    mem_d[widx] = in_rec[i];
                    n_acc       = n_acc + 1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        wptr_d      = PW'((int'(wptr_q) + n_acc) % DEPTH);
        rptr_d      = pop ? PW'((int'(rptr_q) + 1) % DEPTH) : rptr_q;
        count_d     = count_q - CW'(pop) + CW'(n_acc);
        out_valid_d = pop;
        out_rec_d   = pop ? mem_q[rptr_q] : '0;
    end

    // Storage is not reset; a cleared count makes stale entries unreachable.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_rec_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_rec_q   <= out_rec_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef RVFI_SERIALIZER_ORDERCHK_EN
    logic        seen_q, seen_d;
    logic [63:0] expected_q, expected_d;
    logic        order_error_q, order_error_d;

    // Checks the registered output, so an error shows one cycle after the bad record.
    always_comb begin
        seen_d        = seen_q;
        expected_d    = expected_q;
        order_error_d = order_error_q;
        if (out_valid_q) begin
            if (seen_q && (out_rec_q.order != expected_q)) begin
                order_error_d = 1'b1;
            end
            expected_d = out_rec_q.order + 64'd1;
            seen_d     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seen_q        <= 1'b0;
            expected_q    <= '0;
            order_error_q <= 1'b0;
        end else begin
            seen_q        <= seen_d;
            expected_q    <= expected_d;
            order_error_q <= order_error_d;
        end
    end

    assign bus.order_error = order_error_q;
`else
    assign bus.order_error = 1'b0;
`endif

    assign bus.out_valid     = out_valid_q;
    assign bus.out_order     = out_rec_q.order;
    assign bus.out_insn      = out_rec_q.insn;
    assign bus.out_trap      = out_rec_q.trap;
    assign bus.out_halt      = out_rec_q.halt;
    assign bus.out_intr      = out_rec_q.intr;
    assign bus.out_rs1_addr  = out_rec_q.rs1_addr;
    assign bus.out_rs2_addr  = out_rec_q.rs2_addr;
    assign bus.out_rd_addr   = out_rec_q.rd_addr;
    assign bus.out_rs1_rdata = out_rec_q.rs1_rdata;
    assign bus.out_rs2_rdata = out_rec_q.rs2_rdata;
    assign bus.out_rd_wdata  = out_rec_q.rd_wdata;
    assign bus.out_pc_rdata  = out_rec_q.pc_rdata;
    assign bus.out_pc_wdata  = out_rec_q.pc_wdata;
    assign bus.out_mem_addr  = out_rec_q.mem_addr;
    assign bus.out_mem_rmask = out_rec_q.mem_rmask;
    assign bus.out_mem_wmask = out_rec_q.mem_wmask;
    assign bus.out_mem_rdata = out_rec_q.mem_rdata;
    assign bus.out_mem_wdata = out_rec_q.mem_wdata;
    assign bus.overflow      = overflow_q;
endmodule
